// File: rtl/boot_seq_pkg.sv
// ----------------------------------------------------------------------------
// boot_seq_pkg
// Types and constants shared by the boot/start sequencer and its helpers.
//   boot_state_t   : FSM state encoding (also exported on state_o for debug)
//   SP_REG_ADDR    : architectural register written with the initial stack
//                    pointer on every start (x2 / sp)
//   sat_inc8()     : saturating 8-bit increment used by the boot counter
// ----------------------------------------------------------------------------
package boot_seq_pkg;

  typedef enum logic [2:0] {
    POR_WAIT = 3'd0,
    IDLE     = 3'd1,
    START    = 3'd2,
    RUN      = 3'd3,
    HOLD     = 3'd4,
    RELEASE  = 3'd5
  } boot_state_t;

  localparam logic [4:0] SP_REG_ADDR    = 5'd2;
  localparam logic [7:0] BOOT_COUNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == BOOT_COUNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage : boot_seq_pkg

// File: rtl/prio_addr_select.sv
// ----------------------------------------------------------------------------
// prio_addr_select
// Combinational priority encoder plus address mux. The lowest set index of
// req_i wins and its XLEN-wide slice of addr_i is returned.
//   req_i   [NUM_SRC]        : request vector, index 0 = highest priority
//   addr_i  [NUM_SRC*XLEN]   : per-source address, slice i for req_i[i]
//   valid_o                  : at least one request is set
//   addr_o  [XLEN]           : address of the winning source (0 when none)
// ----------------------------------------------------------------------------
module prio_addr_select #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0]      req_i,
  input  logic [NUM_SRC*XLEN-1:0] addr_i,
  output logic                    valid_o,
  output logic [XLEN-1:0]         addr_o
);

  // NOTE: every signal assigned in always_comb gets a default first so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    valid_o = 1'b0;
    addr_o  = '0;
    // Ascending scan; the first hit locks out the lower-priority sources.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req_i[i] && !valid_o) begin
        valid_o = 1'b1;
        addr_o  = addr_i[i*XLEN +: XLEN];
      end
    end
  end

endmodule : prio_addr_select

// File: rtl/boot_start_sequencer.sv
// ----------------------------------------------------------------------------
// boot_start_sequencer
// CPU boot/start controller between the debug coprocessor (hardware loader)
// and the MCU core. Provides a power-on delay, prioritised start requesters,
// CPU reset hold/release sequencing, pending-start capture, stack-pointer
// initialisation and a saturating boot counter.
//   clk, reset_n       : clock, asynchronous active-low reset
//   cpu_reset_req      : level, holds the CPU in reset while high
//   start_req          : single-cycle start requests, index 0 highest priority
//   start_addr_in      : per-source start address, slice i for start_req[i]
//   cpu_reset_n_out    : CPU reset, active-low
//   start_pulse        : one-cycle start strobe
//   start_addr         : start address, stable until the next start
//   sp_we/waddr/wdata  : register-file write of the initial stack pointer
//   pending            : a start is latched and waiting for reset release
//   boot_count         : saturating count of issued start pulses
//   state_o            : current FSM state
// ----------------------------------------------------------------------------
module boot_start_sequencer
  import boot_seq_pkg::*;
#(
  parameter int              XLEN               = 32,
  parameter int              NUM_SRC            = 2,
  parameter int              POR_DELAY          = 4,
  parameter int              RELEASE_DELAY      = 2,
  parameter bit              AUTO_START         = 1'b1,
  parameter logic [XLEN-1:0] DEFAULT_START_ADDR = 32'h8000_0000,
  parameter logic [XLEN-1:0] DEFAULT_STACK_ADDR = 32'h8000_3FF0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cpu_reset_req,
  input  logic [NUM_SRC-1:0]      start_req,
  input  logic [NUM_SRC*XLEN-1:0] start_addr_in,
  output logic                    cpu_reset_n_out,
  output logic                    start_pulse,
  output logic [XLEN-1:0]         start_addr,
  output logic                    sp_we,
  output logic [4:0]              sp_waddr,
  output logic [XLEN-1:0]         sp_wdata,
  output logic                    pending,
  output logic [7:0]              boot_count,
  output logic [2:0]              state_o
);

  localparam int MAX_DELAY = (POR_DELAY > RELEASE_DELAY) ? POR_DELAY : RELEASE_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY) + 1;

  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_DELAY - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_DELAY - 1);

  boot_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              pulse_q, pulse_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              pend_q, pend_d;
  logic [XLEN-1:0]   pend_addr_q, pend_addr_d;
  logic [7:0]        count_q, count_d;

  logic              req_valid;
  logic [XLEN-1:0]   req_addr;
  logic              capture_valid;
  logic [XLEN-1:0]   capture_addr;
  logic              launch;
  logic [XLEN-1:0]   launch_addr;

  prio_addr_select #(
    .XLEN    (XLEN),
    .NUM_SRC (NUM_SRC)
  ) u_select (
    .req_i   (start_req),
    .addr_i  (start_addr_in),
    .valid_o (req_valid),
    .addr_o  (req_addr)
  );

  // A request arriving this cycle overrides any older pending address.
  assign capture_valid = pend_q | req_valid;
  assign capture_addr  = req_valid ? req_addr : pend_addr_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    addr_d      = addr_q;
    count_d     = count_q;
    launch      = 1'b0;
    launch_addr = addr_q;

    unique case (state_q)
      POR_WAIT: begin
        pend_d      = capture_valid;
        pend_addr_d = capture_addr;
        if (cnt_q == POR_LAST) begin
          cnt_d = '0;
          if (cpu_reset_req) begin
            state_d = HOLD;
          end else if (capture_valid) begin
            launch      = 1'b1;
            launch_addr = capture_addr;
          end else if (AUTO_START) begin
            launch      = 1'b1;
            launch_addr = DEFAULT_START_ADDR;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      IDLE, START, RUN: begin
        if (cpu_reset_req) begin
          // Reset wins over a simultaneous request; the request is kept.
          state_d = HOLD;
          if (req_valid) begin
            pend_d      = 1'b1;
            pend_addr_d = req_addr;
          end
        end else if (req_valid) begin
          launch      = 1'b1;
          launch_addr = req_addr;
        end else if (state_q == START) begin
          state_d = RUN;
        end
      end

      HOLD: begin
        pend_d      = capture_valid;
        pend_addr_d = capture_addr;
        if (!cpu_reset_req) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end

      RELEASE: begin
        pend_d      = capture_valid;
        pend_addr_d = capture_addr;
        if (cpu_reset_req) begin
          state_d = HOLD;
        end else if (cnt_q == REL_LAST) begin
          cnt_d = '0;
          if (capture_valid) begin
            launch      = 1'b1;
            launch_addr = capture_addr;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (launch) begin
      state_d = START;
      addr_d  = launch_addr;
      pend_d  = 1'b0;
      count_d = sat_inc8(count_q);
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  assign cpu_rst_n_d = !((state_d == POR_WAIT) || (state_d == HOLD));
  assign pulse_d     = (state_d == START);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= POR_WAIT;
      cnt_q       <= '0;
      cpu_rst_n_q <= 1'b0;
      pulse_q     <= 1'b0;
      addr_q      <= DEFAULT_START_ADDR;
      pend_q      <= 1'b0;
      pend_addr_q <= DEFAULT_START_ADDR;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      pulse_q     <= pulse_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      count_q     <= count_d;
    end
  end

  assign cpu_reset_n_out = cpu_rst_n_q;
  assign start_pulse     = pulse_q;
  assign sp_we           = pulse_q;
  assign start_addr      = addr_q;
  assign sp_waddr        = SP_REG_ADDR;
  assign sp_wdata        = DEFAULT_STACK_ADDR;
  assign pending         = pend_q;
  assign boot_count      = count_q;
  assign state_o         = state_q;

endmodule : boot_start_sequencer

// File: tb/tb_boot_start_sequencer.sv
// ----------------------------------------------------------------------------
// tb_boot_start_sequencer
// Directed bench for boot_start_sequencer: one instance with default
// parameters and a second with AUTO_START=0 for the power-on pending case.
// ----------------------------------------------------------------------------
module tb_boot_start_sequencer;

  localparam int XLEN = 32;
  localparam int NSRC = 2;

  localparam logic [2:0] S_POR   = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_REL   = 3'd5;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 cpu_reset_req;
  logic [NSRC-1:0]      start_req;
  logic [NSRC*XLEN-1:0] start_addr_in;
  logic                 cpu_reset_n_out, start_pulse, sp_we, pending;
  logic [XLEN-1:0]      start_addr, sp_wdata;
  logic [4:0]           sp_waddr;
  logic [7:0]           boot_count;
  logic [2:0]           state_o;

  logic                 b_reset_n;
  logic                 b_cpu_reset_req;
  logic [NSRC-1:0]      b_start_req;
  logic [NSRC*XLEN-1:0] b_start_addr_in;
  logic                 b_cpu_reset_n_out, b_start_pulse, b_sp_we, b_pending;
  logic [XLEN-1:0]      b_start_addr, b_sp_wdata;
  logic [4:0]           b_sp_waddr;
  logic [7:0]           b_boot_count;
  logic [2:0]           b_state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  boot_start_sequencer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cpu_reset_req   (cpu_reset_req),
    .start_req       (start_req),
    .start_addr_in   (start_addr_in),
    .cpu_reset_n_out (cpu_reset_n_out),
    .start_pulse     (start_pulse),
    .start_addr      (start_addr),
    .sp_we           (sp_we),
    .sp_waddr        (sp_waddr),
    .sp_wdata        (sp_wdata),
    .pending         (pending),
    .boot_count      (boot_count),
    .state_o         (state_o)
  );

  boot_start_sequencer #(.AUTO_START(1'b0)) dut_b (
    .clk             (clk),
    .reset_n         (b_reset_n),
    .cpu_reset_req   (b_cpu_reset_req),
    .start_req       (b_start_req),
    .start_addr_in   (b_start_addr_in),
    .cpu_reset_n_out (b_cpu_reset_n_out),
    .start_pulse     (b_start_pulse),
    .start_addr      (b_start_addr),
    .sp_we           (b_sp_we),
    .sp_waddr        (b_sp_waddr),
    .sp_wdata        (b_sp_wdata),
    .pending         (b_pending),
    .boot_count      (b_boot_count),
    .state_o         (b_state_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " rst_n_out"}, 64'(cpu_reset_n_out), 64'd0);
    check({tag, " pulse"},     64'(start_pulse),     64'd0);
    check({tag, " sp_we"},     64'(sp_we),           64'd0);
    check({tag, " addr"},      64'(start_addr),      64'h8000_0000);
    check({tag, " pending"},   64'(pending),         64'd0);
    check({tag, " count"},     64'(boot_count),      64'd0);
    check({tag, " state"},     64'(state_o),         64'(S_POR));
  endtask

  initial begin
    reset_n         = 1'b0;
    cpu_reset_req   = 1'b0;
    start_req       = '0;
    start_addr_in   = '0;
    b_reset_n       = 1'b0;
    b_cpu_reset_req = 1'b0;
    b_start_req     = '0;
    b_start_addr_in = '0;

    // Reset state and constant stack-pointer write port.
    #12;
    check_reset_values("reset");
    check("sp_waddr", 64'(sp_waddr), 64'd2);
    check("sp_wdata", 64'(sp_wdata), 64'h8000_3FF0);

    // Power-on auto start: 4 POR_WAIT cycles, then one pulse.
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("por pulse low", 64'(start_pulse), 64'd0);
      check("por rst_n_out", 64'(cpu_reset_n_out), 64'd0);
    end
    step();
    check("por pulse",     64'(start_pulse),     64'd1);
    check("por sp_we",     64'(sp_we),           64'd1);
    check("por addr",      64'(start_addr),      64'h8000_0000);
    check("por count",     64'(boot_count),      64'd1);
    check("por rst_n_out", 64'(cpu_reset_n_out), 64'd1);
    check("por state",     64'(state_o),         64'(S_START));
    for (int i = 0; i < 3; i++) begin
      step();
      check("por single pulse", 64'(start_pulse), 64'd0);
    end
    check("run state", 64'(state_o), 64'(S_RUN));

    // Both sources request in RUN: source 0 wins, one pulse next cycle.
    start_addr_in = {32'h0000_0200, 32'h0000_0100};
    start_req     = 2'b11;
    step();
    start_req = '0;
    check("prio pulse", 64'(start_pulse), 64'd1);
    check("prio addr",  64'(start_addr),  64'h100);
    check("prio count", 64'(boot_count),  64'd2);
    step();
    check("prio one pulse", 64'(start_pulse), 64'd0);
    check("prio addr hold", 64'(start_addr),  64'h100);

    // Hold for 10 cycles with a source-1 request mid-hold.
    start_addr_in = {32'h0000_0400, 32'h0000_0999};
    cpu_reset_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold rst_n_out", 64'(cpu_reset_n_out), 64'd0);
      check("hold no pulse",  64'(start_pulse),     64'd0);
      if (i == 3) start_req = 2'b10;
      if (i == 4) begin
        start_req = '0;
        check("hold pending", 64'(pending), 64'd1);
      end
    end
    cpu_reset_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rel rst_n_out", 64'(cpu_reset_n_out), 64'd1);
      check("rel no pulse",  64'(start_pulse),     64'd0);
      check("rel state",     64'(state_o),         64'(S_REL));
    end
    step();
    check("rel pulse",   64'(start_pulse), 64'd1);
    check("rel addr",    64'(start_addr),  64'h400);
    check("rel pending", 64'(pending),     64'd0);
    check("rel count",   64'(boot_count),  64'd3);

    // Reset pulse with no request: ends in IDLE, no pulse, address kept.
    step();
    cpu_reset_req = 1'b1;
    step();
    cpu_reset_req = 1'b0;
    check("pulse hold rst_n_out", 64'(cpu_reset_n_out), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("pulse no start", 64'(start_pulse), 64'd0);
    end
    check("idle state",     64'(state_o),         64'(S_IDLE));
    check("idle addr",      64'(start_addr),      64'h400);
    check("idle rst_n_out", 64'(cpu_reset_n_out), 64'd1);
    check("idle pending",   64'(pending),         64'd0);

    // Request and reset together: latched as pending, no pulse.
    start_addr_in = {32'h0000_0200, 32'h0000_0600};
    start_req     = 2'b01;
    cpu_reset_req = 1'b1;
    step();
    start_req     = '0;
    cpu_reset_req = 1'b0;
    check("simul state",   64'(state_o),     64'(S_HOLD));
    check("simul pending", 64'(pending),     64'd1);
    check("simul pulse",   64'(start_pulse), 64'd0);
    step();
    step();
    step();
    check("simul start pulse", 64'(start_pulse), 64'd1);
    check("simul start addr",  64'(start_addr),  64'h600);
    check("simul count",       64'(boot_count),  64'd4);

    // Back-to-back requests: pulse every cycle, counter saturates.
    start_req = 2'b01;
    for (int i = 0; i < 300; i++) step();
    check("b2b pulse", 64'(start_pulse), 64'd1);
    check("b2b state", 64'(state_o),     64'(S_START));
    check("sat count", 64'(boot_count),  64'd255);
    start_req = '0;
    step();
    check("sat after", 64'(boot_count), 64'd255);

    // Reset request does not clear boot_count; async reset mid-RELEASE does.
    cpu_reset_req = 1'b1;
    step();
    cpu_reset_req = 1'b0;
    step();
    check("mid rel state", 64'(state_o),    64'(S_REL));
    check("mid rel count", 64'(boot_count), 64'd255);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_values("async");

    // AUTO_START=0 instance: request during POR_WAIT fires at expiry.
    @(posedge clk);
    #2;
    b_reset_n = 1'b1;
    step();
    b_start_addr_in = {32'h0000_0300, 32'h0000_0080};
    b_start_req     = 2'b01;
    step();
    b_start_req = '0;
    check("b pending",   64'(b_pending),         64'd1);
    check("b rst_n_out", 64'(b_cpu_reset_n_out), 64'd0);
    check("b no pulse",  64'(b_start_pulse),     64'd0);
    step();
    check("b no pulse2", 64'(b_start_pulse), 64'd0);
    step();
    check("b pulse",   64'(b_start_pulse), 64'd1);
    check("b addr",    64'(b_start_addr),  64'h80);
    check("b count",   64'(b_boot_count),  64'd1);
    check("b pend clr", 64'(b_pending),    64'd0);
    step();
    check("b one pulse", 64'(b_start_pulse), 64'd0);
    check("b run",       64'(b_state_o),     64'(S_RUN));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_boot_start_sequencer
